// File: rtl/modular_add.sv
// Limb-serial modular adder/subtractor over GF(PRIME); one operation per Reset release.
// Raw add/sub over N limbs, then one trial correction over N limbs, then a single select.
module modular_add #(
  parameter int unsigned P_WIDTH    = 256,
  parameter int unsigned LIMB_WIDTH = 64,
  parameter logic [P_WIDTH-1:0] PRIME =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               op,
  input  logic [P_WIDTH-1:0] a,
  input  logic [P_WIDTH-1:0] b,
  output logic [P_WIDTH-1:0] sum,
  output logic               Done
);

  localparam int unsigned N  = P_WIDTH / LIMB_WIDTH;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {LOAD, OP, FIX, DONE} state_t;

  state_t             state;
  logic [P_WIDTH-1:0] ra, rb, pr, raw, trial;
  logic               rop, carry, c_raw;
  logic [CW-1:0]      cnt;

  logic [LIMB_WIDTH:0]  op_res, fix_res;
  logic [P_WIDTH-1:0]   raw_op_next, raw_rot_next, trial_next, result;
  logic                 use_trial;

  // Shift a new limb in at the top while dropping the consumed bottom limb.
  function automatic logic [P_WIDTH-1:0] shift_in(input logic [P_WIDTH-1:0] v,
                                                  input logic [LIMB_WIDTH-1:0] l);
    return (v >> LIMB_WIDTH) | (P_WIDTH'(l) << (P_WIDTH - LIMB_WIDTH));
  endfunction

  always_comb begin
    op_res  = '0;
    fix_res = '0;
    if (rop) begin
      op_res  = {1'b0, ra[LIMB_WIDTH-1:0]} - {1'b0, rb[LIMB_WIDTH-1:0]}
              - {{LIMB_WIDTH{1'b0}}, carry};
      fix_res = {1'b0, raw[LIMB_WIDTH-1:0]} + {1'b0, pr[LIMB_WIDTH-1:0]}
              + {{LIMB_WIDTH{1'b0}}, carry};
    end else begin
      op_res  = {1'b0, ra[LIMB_WIDTH-1:0]} + {1'b0, rb[LIMB_WIDTH-1:0]}
              + {{LIMB_WIDTH{1'b0}}, carry};
      fix_res = {1'b0, raw[LIMB_WIDTH-1:0]} - {1'b0, pr[LIMB_WIDTH-1:0]}
              - {{LIMB_WIDTH{1'b0}}, carry};
    end
    raw_op_next  = shift_in(raw, op_res[LIMB_WIDTH-1:0]);
    // raw is rotated during FIX so it is intact again once the trial is complete.
    raw_rot_next = shift_in(raw, raw[LIMB_WIDTH-1:0]);
    trial_next   = shift_in(trial, fix_res[LIMB_WIDTH-1:0]);
    // In DONE, carry holds the final borrow (add) or carry (sub) of the trial chain.
    use_trial    = rop ? c_raw : (c_raw | ~carry);
    result       = use_trial ? trial : raw;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= LOAD;
      ra    <= '0;
      rb    <= '0;
      pr    <= '0;
      raw   <= '0;
      trial <= '0;
      rop   <= 1'b0;
      carry <= 1'b0;
      c_raw <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      Done  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          ra    <= a;
          rb    <= b;
          rop   <= op;
          pr    <= PRIME;
          raw   <= '0;
          trial <= '0;
          carry <= 1'b0;
          c_raw <= 1'b0;
          cnt   <= '0;
          state <= OP;
        end
        OP: begin
          ra    <= ra >> LIMB_WIDTH;
          rb    <= rb >> LIMB_WIDTH;
          raw   <= raw_op_next;
          carry <= op_res[LIMB_WIDTH];
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            c_raw <= op_res[LIMB_WIDTH];
            carry <= 1'b0;
            cnt   <= '0;
            state <= FIX;
          end
        end
        FIX: begin
          pr    <= pr >> LIMB_WIDTH;
          raw   <= raw_rot_next;
          trial <= trial_next;
          carry <= fix_res[LIMB_WIDTH];
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= DONE;
          end
        end
        DONE: begin
          sum  <= result;
          Done <= 1'b1;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_modular_add.sv
// Directed and random checks of modular_add: values, latency, stability, capture and abort.
module tb_modular_add;

  localparam logic [255:0] P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         op = 1'b0;
  logic [255:0] a = '0;
  logic [255:0] b = '0;
  logic [255:0] sum;
  logic         Done;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 Clk = ~Clk;

  modular_add #(.P_WIDTH(256), .LIMB_WIDTH(64), .PRIME(P)) dut (
    .Clk(Clk), .Reset(Reset), .op(op), .a(a), .b(b), .sum(sum), .Done(Done)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent reference: exact modular result for operands in [0, P-1].
  function automatic logic [255:0] ref_mod(input logic [255:0] x, input logic [255:0] y,
                                           input logic o);
    logic [256:0] t;
    if (!o) begin
      t = {1'b0, x} + {1'b0, y};
      if (t >= {1'b0, P}) t = t - {1'b0, P};
    end else if (x >= y) begin
      t = {1'b0, x} - {1'b0, y};
    end else begin
      t = {1'b0, x} + {1'b0, P} - {1'b0, y};
    end
    return t[255:0];
  endfunction

  function automatic logic [255:0] rand_fe();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    if (v >= P) v = v - P;
    return v;
  endfunction

  task automatic release_op(input logic [255:0] ta, input logic [255:0] tb_, input logic top);
    a = ta; b = tb_; op = top;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
  endtask

  // Counts edges until Done; expired budget shows up as a latency miscompare.
  task automatic wait_done(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge Clk); #1;
      if (Done === 1'b1) begin
        lat = i;
        break;
      end
    end
    check({tag, " latency"}, 256'(lat), 256'(exp_lat));
  endtask

  task automatic run(input logic [255:0] ta, input logic [255:0] tb_, input logic top,
                     input logic [255:0] exp, input string tag);
    release_op(ta, tb_, top);
    wait_done(tag, 10);
    check(tag, sum, exp);
  endtask

  initial begin
    logic [255:0] ra, rb;
    logic         ro;

    // Reset held two cycles
    a = 256'd123; b = 256'd456; op = 1'b0; Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check("reset sum", sum, '0);
    check("reset done", {255'd0, Done}, 256'd0);
    Reset = 1'b0;
    wait_done("add 123+456", 10);
    check("add 123+456", sum, 256'd579);
    for (int i = 0; i < 20; i++) begin
      @(posedge Clk); #1;
      check("hold done", {255'd0, Done}, 256'd1);
      check("hold sum", sum, 256'd579);
    end

    run(256'd456, 256'd123, 1'b1, 256'd333, "sub 456-123");
    run(256'd123, 256'd456, 1'b1, P - 256'd333, "sub 123-456");
    run(P - 256'd1, 256'd1, 1'b0, 256'd0, "add to P");
    run(P - 256'd1, P - 256'd1, 1'b0, P - 256'd2, "add carry-out");
    run(256'd0, 256'd1, 1'b1, P - 256'd1, "sub 0-1");
    run(256'h1234, 256'h1234, 1'b1, 256'd0, "sub equal");
    run(256'd9, P + 256'h200, 1'b0, 256'h209, "add unreduced");

    // Inputs changed after the LOAD edge must be ignored
    release_op(256'd1000, 256'd24, 1'b0);
    @(posedge Clk); #1;
    a = 256'd5; b = 256'd7; op = 1'b1;
    wait_done("late change", 9);
    check("late change", sum, 256'd1024);

    // Abort during FIX
    release_op(256'd77, 256'd88, 1'b0);
    repeat (7) @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    check("abort done", {255'd0, Done}, 256'd0);
    check("abort sum", sum, '0);
    run(256'd77, 256'd88, 1'b0, 256'd165, "after abort");

    for (int i = 0; i < 8; i++) begin
      ra = rand_fe();
      rb = rand_fe();
      ro = 1'($urandom_range(0, 1));
      run(ra, rb, ro, ref_mod(ra, rb, ro), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
